// File: rtl/integrator_sequencer_if.sv
// Control handshake between the integrator sequencer, the sample producer and the
// accumulator datapath. The slave side is the sequencer.
interface integrator_sequencer_if;
  logic       enable;
  logic       clear_req;
  logic       sample_valid;
  logic       sample_ready;
  logic       hold;
  logic       buffer;
  logic       RESET;
  logic       block_done;
  logic [7:0] sample_idx;
  logic [7:0] block_count;

  modport slave (
    input  enable, clear_req, sample_valid,
    output sample_ready, hold, buffer, RESET, block_done, sample_idx, block_count
  );

  modport master (
    output enable, clear_req, sample_valid,
    input  sample_ready, hold, buffer, RESET, block_done, sample_idx, block_count
  );
endinterface

// File: rtl/integrator_sequencer.sv
// Sequences an external accumulator over blocks of block_len samples: loads the
// first sample, adds the rest, and pulses block_done when a block sum is ready.
module integrator_sequencer #(
  parameter int block_len = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  integrator_sequencer_if.slave bus
);
  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] ACCUM = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [7:0] last_idx = 8'(block_len - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] idx, idx_nxt;
  logic [7:0] count, count_nxt;
  logic       ready, accept;

  assign ready  = ((state == IDLE) || (state == ACCUM)) && bus.enable && !bus.clear_req;
  assign accept = ready && bus.sample_valid;

  assign bus.sample_ready = ready;
  assign bus.hold         = !accept;
  assign bus.buffer       = accept && (state == IDLE);
  assign bus.RESET        = (state == CLEAR);
  assign bus.block_done   = (state == DONE);
  assign bus.sample_idx   = idx;
  assign bus.block_count  = count;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    count_nxt = count;
    // Soft clear outranks everything, including the count bump in DONE.
    if (bus.clear_req) begin
      state_nxt = CLEAR;
      idx_nxt   = 8'd0;
      count_nxt = 8'd0;
    end else begin
      case (state)
        CLEAR: begin
          state_nxt = IDLE;
          idx_nxt   = 8'd0;
        end
        IDLE: begin
          if (accept) begin
            state_nxt = ACCUM;
            idx_nxt   = 8'd1;
          end
        end
        ACCUM: begin
          if (!bus.enable) begin
            state_nxt = IDLE;
            idx_nxt   = 8'd0;
          end else if (accept) begin
            if (idx == last_idx) begin
              state_nxt = DONE;
              idx_nxt   = 8'd0;
            end else begin
              idx_nxt = idx + 8'd1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          count_nxt = count + 8'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      idx   <= 8'd0;
      count <= 8'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      count <= count_nxt;
    end
  end
endmodule

// File: tb/tb_integrator_sequencer.sv
// Directed bench for integrator_sequencer with a behavioural accumulator driven
// by the hold/buffer/RESET controls.
module tb_integrator_sequencer;
  logic        clock;
  logic        reset;
  logic [15:0] data;
  logic [15:0] acc;
  int          checks;
  int          errors;

  integrator_sequencer_if bus();

  integrator_sequencer #(.block_len(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or negedge reset) begin
    if (!reset)        acc <= 16'd0;
    else if (bus.RESET) acc <= 16'd0;
    else if (!bus.hold) acc <= bus.buffer ? data : acc + data;
  end

  typedef struct {
    logic        en, clr, vld;
    logic [15:0] din;
    logic        rdy, hld, bfr, rst, dn;
    logic [7:0]  idx, cnt;
    logic [15:0] acc;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(input logic en, clr, vld, input int din,
                              input logic rdy, hld, bfr, rst, dn,
                              input int idx, cnt, accv);
    vec_t v;
    v.en = en; v.clr = clr; v.vld = vld; v.din = 16'(din);
    v.rdy = rdy; v.hld = hld; v.bfr = bfr; v.rst = rst; v.dn = dn;
    v.idx = 8'(idx); v.cnt = 8'(cnt); v.acc = 16'(accv);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, clr, vld, input int din);
    bus.enable = en; bus.clear_req = clr; bus.sample_valid = vld; data = 16'(din);
  endtask

  int done_seen;

  initial begin
    checks = 0; errors = 0;
    drive(1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;

    //          en clr vld din  rdy hld buf RST dn idx cnt acc
    vecs[0]  = mk(1, 0, 1, 1,   0, 1, 0, 1, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 1, 1,   1, 0, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 1, 2,   1, 0, 0, 0, 0, 1, 0, 1);
    vecs[3]  = mk(1, 0, 1, 3,   1, 0, 0, 0, 0, 2, 0, 3);
    vecs[4]  = mk(1, 0, 1, 4,   1, 0, 0, 0, 0, 3, 0, 6);
    vecs[5]  = mk(1, 0, 1, 5,   0, 1, 0, 0, 1, 0, 0, 10);
    vecs[6]  = mk(1, 0, 1, 5,   1, 0, 1, 0, 0, 0, 1, 10);
    vecs[7]  = mk(1, 0, 1, 6,   1, 0, 0, 0, 0, 1, 1, 5);
    vecs[8]  = mk(1, 0, 1, 7,   1, 0, 0, 0, 0, 2, 1, 11);
    vecs[9]  = mk(1, 0, 1, 8,   1, 0, 0, 0, 0, 3, 1, 18);
    vecs[10] = mk(1, 0, 0, 0,   0, 1, 0, 0, 1, 0, 1, 26);
    vecs[11] = mk(1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 2, 26);
    vecs[12] = mk(1, 0, 1, 3,   1, 0, 1, 0, 0, 0, 2, 26);
    vecs[13] = mk(1, 0, 1, 4,   1, 0, 0, 0, 0, 1, 2, 3);
    vecs[14] = mk(0, 0, 1, 9,   0, 1, 0, 0, 0, 2, 2, 7);
    vecs[15] = mk(0, 0, 1, 9,   0, 1, 0, 0, 0, 0, 2, 7);
    vecs[16] = mk(0, 0, 1, 9,   0, 1, 0, 0, 0, 0, 2, 7);
    vecs[17] = mk(1, 0, 1, 2,   1, 0, 1, 0, 0, 0, 2, 7);
    vecs[18] = mk(1, 0, 0, 0,   1, 1, 0, 0, 0, 1, 2, 2);
    vecs[19] = mk(1, 1, 1, 5,   0, 1, 0, 0, 0, 1, 2, 2);
    vecs[20] = mk(1, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0, 2);
    vecs[21] = mk(1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0);
    vecs[22] = mk(1, 0, 1, 1,   1, 0, 1, 0, 0, 0, 0, 0);
    vecs[23] = mk(1, 0, 1, 1,   1, 0, 0, 0, 0, 1, 0, 1);
    vecs[24] = mk(1, 0, 1, 1,   1, 0, 0, 0, 0, 2, 0, 2);
    vecs[25] = mk(1, 0, 1, 1,   1, 0, 0, 0, 0, 3, 0, 3);
    vecs[26] = mk(1, 1, 0, 0,   0, 1, 0, 0, 1, 0, 0, 4);
    vecs[27] = mk(1, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0, 4);
    vecs[28] = mk(1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0);

    tick(); tick();
    // Reset state with enable and valid already asserted.
    drive(1'b1, 1'b0, 1'b1, 1);
    #2;
    chk("rst_ready", int'(bus.sample_ready), 0);
    chk("rst_hold",  int'(bus.hold), 1);
    chk("rst_buffer", int'(bus.buffer), 0);
    chk("rst_RESET", int'(bus.RESET), 1);
    chk("rst_done",  int'(bus.block_done), 0);
    chk("rst_idx",   int'(bus.sample_idx), 0);
    chk("rst_count", int'(bus.block_count), 0);
    reset = 1'b1;
    #1;

    for (int i = 0; i < 29; i++) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].vld, int'(vecs[i].din));
      #3;
      chk($sformatf("v%0d_ready", i),  int'(bus.sample_ready), int'(vecs[i].rdy));
      chk($sformatf("v%0d_hold", i),   int'(bus.hold),         int'(vecs[i].hld));
      chk($sformatf("v%0d_buffer", i), int'(bus.buffer),       int'(vecs[i].bfr));
      chk($sformatf("v%0d_RESET", i),  int'(bus.RESET),        int'(vecs[i].rst));
      chk($sformatf("v%0d_done", i),   int'(bus.block_done),   int'(vecs[i].dn));
      chk($sformatf("v%0d_idx", i),    int'(bus.sample_idx),   int'(vecs[i].idx));
      chk($sformatf("v%0d_count", i),  int'(bus.block_count),  int'(vecs[i].cnt));
      chk($sformatf("v%0d_acc", i),    int'(acc),              int'(vecs[i].acc));
      tick();
    end

    // 256 back-to-back blocks: count wraps, one pulse per block.
    done_seen = 0;
    for (int b = 0; b < 256; b++) begin
      for (int k = 0; k < 5; k++) begin
        drive(1'b1, 1'b0, (k < 4), 1);
        #3;
        if (b == 255 && k == 0) chk("wrap_count_255", int'(bus.block_count), 255);
        if (bus.block_done) done_seen++;
        tick();
      end
    end
    drive(1'b1, 1'b0, 1'b0, 0);
    #3;
    chk("wrap_done_pulses", done_seen, 256);
    chk("wrap_count_0", int'(bus.block_count), 0);
    chk("wrap_acc", int'(acc), 4);
    tick();

    // One full block, then two samples of a partial block before an async reset.
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 1'b0, (k != 4), 1);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 1);
    #3;
    chk("pre_rst_count", int'(bus.block_count), 1);
    chk("pre_rst_idx", int'(bus.sample_idx), 2);
    reset = 1'b0;
    #1;
    chk("async_ready", int'(bus.sample_ready), 0);
    chk("async_hold",  int'(bus.hold), 1);
    chk("async_buffer", int'(bus.buffer), 0);
    chk("async_RESET", int'(bus.RESET), 1);
    chk("async_done",  int'(bus.block_done), 0);
    chk("async_idx",   int'(bus.sample_idx), 0);
    chk("async_count", int'(bus.block_count), 0);
    chk("async_acc",   int'(acc), 0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("post_rst_done", int'(bus.block_done), 0);
    tick();
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, 1'b0, (j < 4), j + 1);
      #3;
      chk($sformatf("rblk%0d_done", j), int'(bus.block_done), (j == 4) ? 1 : 0);
      if (j == 0) chk("rblk_first_buffer", int'(bus.buffer), 1);
      if (j == 4) chk("rblk_sum", int'(acc), 10);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 0);
    #3;
    chk("rblk_count", int'(bus.block_count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
